// File: rtl/mux4to1_rr_stream.sv
// mux4to1_rr_stream: four valid/ready input streams merged onto one registered
// output stream. Round-robin arbitration; out_sel tags the source channel.
module mux4to1_rr_stream #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [4*WIDTH-1:0] in_data,
  input  logic [3:0]         in_valid,
  output logic [3:0]         in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         out_sel,
  output logic               out_valid,
  input  logic               out_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                     state, nstate;
  logic [3:0][WIDTH-1:0]      ch_data;
  logic [1:0]                 rr_last;
  logic [1:0]                 gidx;
  logic                       gany;
  logic [3:0]                 grant;
  logic                       load_en;
  logic                       accept;

  assign ch_data = in_data;

  // Round-robin search starting one past the last winner; first valid wins.
  always_comb begin
    logic [1:0] idx;
    idx  = '0;
    gidx = '0;
    gany = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = rr_last + 2'(k);
      if (!gany && in_valid[idx]) begin
        gany = 1'b1;
        gidx = idx;
      end
    end
    grant = gany ? (4'b0001 << gidx) : 4'b0000;
  end

  // Output-register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= nstate;
  end

  // Next state: whenever the register may load, it ends up FULL iff a grant exists.
  always_comb begin
    nstate = state;
    case (state)
      EMPTY: nstate = gany ? FULL : EMPTY;
      FULL:  if (out_ready) nstate = gany ? FULL : EMPTY;
      default: nstate = EMPTY;
    endcase
  end

  // FSM outputs. Loading is blocked while reset is held so no upstream word
  // is handshaked and then silently lost.
  always_comb begin
    out_valid = (state == FULL);
    load_en   = rst_n && ((state == EMPTY) || out_ready);
    accept    = load_en && gany;
    in_ready  = load_en ? grant : 4'b0000;
  end

  // Capture the granted word and remember the winner for the next search.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_sel  <= 2'd0;
      rr_last  <= 2'd3;
    end else if (accept) begin
      out_data <= ch_data[gidx];
      out_sel  <= gidx;
      rr_last  <= gidx;
    end
  end

endmodule
